// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and operation-class decode for the
// multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle logic/arithmetic slice: AND/OR/ADD/SUB/SLT/NOR with signed
// overflow and an illegal-opcode flag.
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry_msb;
  logic             ovf;

  // SUB and SLT share the adder as a + ~b + 1.
  assign sub_sel   = (op_i == OP_SUB) || (op_i == OP_SLT);
  assign b_eff     = sub_sel ? ~b_i : b_i;
  assign sum       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
  assign carry_msb = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
  assign ovf       = carry_msb ^ sum[WIDTH];

  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    illegal_o  = 1'b0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_ADD, OP_SUB: begin
        result_o   = sum[WIDTH-1:0];
        overflow_o = ovf;
      end
      OP_SLT: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_NOR: result_o = ~(a_i | b_i);
      // Iterative ops are legal but computed by the sequencer in the top.
      OP_MUL, OP_DIVU, OP_REMU: begin
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle ops via alu_comb_unit, iterative
// shift-add multiply and restoring divide, registered result and flags.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;     // MUL accumulator / divide remainder
  logic [WIDTH-1:0] b_q, b_d;     // MUL multiplicand / divisor
  logic [WIDTH-1:0] c_q, c_d;     // MUL multiplier / dividend-quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] comb_res;
  logic             comb_ovf;
  logic             comb_ill;
  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [WIDTH-1:0] div_quo_nxt;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] dz_res;

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .op_i      (op),
    .a_i       (src1),
    .b_i       (src2),
    .result_o  (comb_res),
    .overflow_o(comb_ovf),
    .illegal_o (comb_ill)
  );

  assign mul_acc_nxt = c_q[0] ? (a_q + b_q) : a_q;

  // Restoring divide: shift the next dividend bit into the remainder and keep
  // the difference only when it did not go negative.
  assign rem_shift   = {a_q, c_q[WIDTH-1]};
  assign rem_diff    = rem_shift - {1'b0, b_q};
  assign div_rem_nxt = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
  assign div_quo_nxt = {c_q[WIDTH-2:0], ~rem_diff[WIDTH]};

  assign iter_res = (op_q == OP_MUL)  ? mul_acc_nxt :
                    (op_q == OP_DIVU) ? div_quo_nxt : div_rem_nxt;
  assign dz_res   = (op == OP_DIVU) ? '1 : src1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = op;
          ovf_d = 1'b0;
          dz_d  = 1'b0;
          ill_d = 1'b0;
          if (!is_iterative(op)) begin
            result_d = comb_res;
            zero_d   = (comb_res == '0);
            ovf_d    = comb_ovf;
            ill_d    = comb_ill;
            state_d  = ST_DONE;
          end else if ((op != OP_MUL) && (src2 == '0)) begin
            result_d = dz_res;
            zero_d   = (dz_res == '0);
            dz_d     = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d   = '0;
            a_d     = '0;
            b_d     = (op == OP_MUL) ? src1 : src2;
            c_d     = (op == OP_MUL) ? src2 : src1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_MUL) begin
          a_d = mul_acc_nxt;
          b_d = {b_q[WIDTH-2:0], 1'b0};
          c_d = {1'b0, c_q[WIDTH-1:1]};
        end else begin
          a_d = div_rem_nxt;
          c_d = div_quo_nxt;
        end
        if (cnt_q == LAST_STEP) begin
          result_d = iter_res;
          zero_d   = (iter_res == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_zero    = dz_q;
  assign illegal     = ill_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed cases plus randomized traffic checked
// every cycle against an arithmetic model of the ALU.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk_i;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         div_zero;
  logic         illegal;
  logic [1:0]   dbg_state_o;

  int tests = 0;
  int fails = 0;

  // Expected packet layout: {result, zero, overflow, div_zero, illegal}
  logic [W+3:0] exp_q[$];
  int           exp_lat;
  int           lat;
  logic         outstanding = 1'b0;
  logic         seen;
  logic [W+3:0] last_pkt;
  int           last_lat;
  int           ready_mode = 1;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .div_zero   (div_zero),
    .illegal    (illegal),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+3:0] model(input logic [3:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         ov, dz, il;
    longint       sa, sb, s;
    logic [63:0]  p;
    r  = '0;
    ov = 1'b0;
    dz = 1'b0;
    il = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s  = sa + sb;
        r  = a + b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s  = sa - sb;
        r  = a - b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b1100: r = ~(a | b);
      4'b1000: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[W-1:0];
      end
      4'b1001: begin
        if (b == 0) begin r = '1; dz = 1'b1; end
        else r = a / b;
      end
      4'b1010: begin
        if (b == 0) begin r = a; dz = 1'b1; end
        else r = a % b;
      end
      default: il = 1'b1;
    endcase
    return {r, (r == 0), ov, dz, il};
  endfunction

  function automatic int model_lat(input logic [3:0] o, input logic [W-1:0] b);
    if (o == 4'b1000) return W + 1;
    if ((o == 4'b1001 || o == 4'b1010) && b != 0) return W + 1;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk_i) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 1'b0;
      seen        = 1'b0;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_outputs", 64'({result, zero, overflow, div_zero, illegal}), 64'd0);
    end else begin
      lat++;
      if (outstanding) begin
        chk("in_ready_while_busy", 64'(in_ready), 64'd0);
        if (out_valid) begin
          if (!seen) begin
            chk("latency", 64'(lat), 64'(exp_lat));
            seen     = 1'b1;
            last_lat = lat;
          end
          chk("result_flags", 64'({result, zero, overflow, div_zero, illegal}), 64'(exp_q[0]));
          if (out_ready) begin
            last_pkt    = {result, zero, overflow, div_zero, illegal};
            void'(exp_q.pop_front());
            outstanding = 1'b0;
          end
        end else if (lat >= exp_lat) begin
          chk("out_valid_late", 64'(out_valid), 64'd1);
        end
      end else begin
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        chk("out_valid_idle", 64'(out_valid), 64'd0);
        if (in_valid) begin
          exp_q.push_back(model(op, src1, src2));
          exp_lat     = model_lat(op, src2);
          lat         = 0;
          seen        = 1'b0;
          outstanding = 1'b1;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(posedge clk_i);
    #1;
    op       = o;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk_i);
      if (in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk_i);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      #2;
      if (!outstanding) break;
    end
    if (outstanding) chk("result_timeout", 64'(outstanding), 64'd0);
  endtask

  task automatic pin(input string name, input logic [W-1:0] r, input logic [3:0] flags,
                     input int l);
    chk({name, "_pkt"}, 64'(last_pkt), 64'({r, flags}));
    chk({name, "_lat"}, 64'(last_lat), 64'(l));
  endtask

  // ---------------- main sequence ----------------
  logic [W-1:0] held;
  int           nv;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    src1     = '0;
    src2     = '0;
    lat      = 0;
    exp_lat  = 1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    @(negedge clk_i);
    #2;
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_result", 64'(result), 64'd0);

    // Flags nibble: {zero, overflow, div_zero, illegal}
    ready_mode = 1;
    send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001); wait_idle();
    pin("add_ovf", 32'h8000_0000, 4'b0100, 1);
    send(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001); wait_idle();
    pin("slt_neg", 32'h0000_0001, 4'b0000, 1);
    send(4'b0110, 32'd5, 32'd5); wait_idle();
    pin("sub_zero", 32'h0, 4'b1000, 1);
    send(4'b1000, 32'h0001_0003, 32'h0000_0005); wait_idle();
    pin("mul", 32'h0005_000F, 4'b0000, 33);
    send(4'b1001, 32'd100, 32'd7); wait_idle();
    pin("divu", 32'd14, 4'b0000, 33);
    send(4'b1010, 32'd100, 32'd7); wait_idle();
    pin("remu", 32'd2, 4'b0000, 33);
    send(4'b1001, 32'd5, 32'd0); wait_idle();
    pin("divu_zero", 32'hFFFF_FFFF, 4'b0010, 1);
    send(4'b1010, 32'd9, 32'd0); wait_idle();
    pin("remu_zero", 32'd9, 4'b0010, 1);

    // Backpressure: result held stable while the consumer stalls.
    ready_mode = 0;
    send(4'b0010, 32'd2, 32'd3);
    nv = 0;
    while (!out_valid && nv < 50) begin @(negedge clk_i); #2; nv++; end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    held = 32'd5;
    repeat (5) begin
      @(negedge clk_i);
      #2;
      chk("bp_result_stable", 64'(result), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    ready_mode = 1;
    wait_idle();
    send(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle();
    pin("illegal", 32'h0, 4'b1001, 1);

    // Reset in the middle of a multiply aborts it.
    send(4'b1000, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk_i);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    send(4'b0010, 32'd2, 32'd3); wait_idle();
    pin("add_after_abort", 32'd5, 4'b0000, 1);

    // Randomized back-to-back traffic with random consumer stalls.
    ready_mode = 2;
    for (int t = 0; t < 300; t++) begin
      logic [3:0]   o;
      logic [W-1:0] a, b;
      case ($urandom_range(0, 10))
        0: o = 4'b0000;  1: o = 4'b0001;  2: o = 4'b0010;
        3: o = 4'b0110;  4: o = 4'b0111;  5: o = 4'b1100;
        6: o = 4'b1000;  7: o = 4'b1001;  8: o = 4'b1010;
        default: o = 4'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = 32'($urandom_range(0, 20)); end
        1:       begin a = 32'h7FFF_FFFF ^ 32'($urandom_range(0, 3)); b = 32'h8000_0000 | 32'($urandom_range(0, 3)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      if ($urandom_range(0, 7) == 0) b = '0;
      send(o, a, b);
    end
    ready_mode = 1;
    wait_idle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle integer ALU for the CPU datapath: a WIDTH-bit successor to the bit-sliced combinational ALU. It adds iterative unsigned multiply/divide, registered status flags and a valid/ready handshake on both sides. It sits between the ID/EX operand registers and the writeback mux, and stalls the pipeline through `in_ready` while an iterative operation runs.

## Interface
- `WIDTH`, default 32: operand/result width in bits; must be ≥ 4.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `in_valid` in 1: operand/opcode request valid.
- `in_ready` out 1: block accepts a request this cycle.
- `op` in 4: operation code (see Operation).
- `src1`, `src2` in WIDTH: operands; src1 is the dividend/multiplicand.
- `out_valid` out 1: `result`/flags valid.
- `out_ready` in 1: consumer takes result this cycle.
- `result` out WIDTH: registered result.
- `zero` out 1: `result == 0`.
- `overflow` out 1: signed overflow (ADD/SUB only, else 0).
- `div_zero` out 1: DIVU/REMU with `src2 == 0`.
- `illegal` out 1: unsupported opcode.

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR — single-cycle class; 1000 MUL (low WIDTH bits of unsigned product), 1001 DIVU (quotient), 1010 REMU (remainder) — iterative class. Any other code: result 0, `illegal`=1, single-cycle class.
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch op/operands. Single-cycle class → compute, register result and flags, go to DONE. Iterative class → load accumulators, counter=0, go to BUSY.
- Divide by zero is resolved in IDLE without entering BUSY: DIVU result = all ones, REMU result = src1, `div_zero`=1, next state DONE.
- BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. After step WIDTH−1 (counter == WIDTH−1), register the result and go to DONE. `in_ready`=0.
- DONE: `out_valid`=1 and outputs held stable until `out_ready`=1. On the handshake cycle go to IDLE. `in_ready`=0 in DONE; no back-to-back overlap.
- Arithmetic: SUB = src1 + ~src2 + 1. Overflow = carry into MSB XOR carry out. SLT uses the true sign (sign of the difference XOR overflow) and returns 1 or 0 zero-extended. MUL discards the upper WIDTH bits.
- `in_valid` outside IDLE is ignored; the requester holds the request until it sees `in_ready`.

## Timing
- Reset (async assert, sync-to-clock deassert by the system): state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, all flags 0, counter=0.
- Latency, accept edge → `out_valid` high:
  - Single-cycle class: 1 cycle.
  - Divide by zero: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Throughput: single-cycle ops, one result per 2 cycles with `out_ready` held high.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately: outputs take reset values and the partial result is lost.
- Simultaneous `out_ready` and `in_valid` in DONE: the result is consumed and the request is not accepted; it is accepted on the next cycle, in IDLE.

## Structure
- Package `alu_pkg`: opcode localparams (`OP_AND` … `OP_REMU`), FSM state enum, class-decode function `is_iterative(op)`.
- Sub-module `alu_comb_unit`: purely combinational WIDTH-bit AND/OR/ADD/SUB/SLT/NOR, producing result, overflow and illegal. Instanced once in the top.
- Top holds the FSM, counter, MUL accumulator/multiplier shift registers, divide remainder/quotient registers and output registers.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, zero=0, `out_valid` exactly 1 cycle after accept.
- SLT 0xFFFFFFFF, 0x00000001 → result 1. SUB 5 − 5 → result 0, zero=1.
- MUL 0x00010003 × 0x00000005 → 0x0005000F, `out_valid` 33 cycles after accept, `in_ready`=0 throughout.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF, div_zero=1, latency 1.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → result stable, `in_ready`=0. Then opcode 1111 → result 0, illegal=1.
- Reset pulse at cycle 10 of a MUL → `out_valid`=0 and `in_ready`=1 immediately. The next ADD 2+3 → 5, with no stale data.
